// File: rtl/tmds_gearbox_10to2.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_gearbox_10to2
//  Summary  : Fast-clock TMDS gearbox. Loads one 2*DIV-bit word per lane
//             every DIV fast cycles and emits it LSB-first as rise/fall bit
//             pairs for DDR output cells. It produces its own word_req load
//             strobe, counts underruns (loads made without valid data) and
//             supports a one-cycle phase slip on a calib rising edge.
//  Options  : GEARBOX_PRBS_EN adds a prbs_mode input and a PRBS7 word source
//             (x^7+x^6+1, seed 7'h7F).
//  Revision : 1.0 - initial release
// ============================================================================
module tmds_gearbox_10to2 #(
    parameter int                 NUM_LANES = 3,
    parameter int                 DIV       = 5,
    parameter logic [2*DIV-1:0]   IDLE_WORD = 10'b1101010100
) (
    input  logic                          hclkin,
    input  logic                          resetn,
    input  logic [NUM_LANES*2*DIV-1:0]    data_in,
    input  logic                          data_valid,
    output logic                          word_req,
    input  logic                          calib,
    output logic [NUM_LANES-1:0]          dout_rise,
    output logic [NUM_LANES-1:0]          dout_fall,
    output logic [7:0]                    underrun_cnt
`ifdef GEARBOX_PRBS_EN
    ,
    input  logic                          prbs_mode
`endif
);

    localparam int               c_WORD_W  = 2 * DIV;
    localparam int               c_PH_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(DIV - 1);

    logic [c_PH_W-1:0]              ph_q, ph_d;
    logic                           word_req_q, word_req_d;
    logic                           calib_q, calib_d;
    logic                           slip_q, slip_d;
    logic [7:0]                     underrun_q, underrun_d;
    logic [NUM_LANES*c_WORD_W-1:0]  sh_q, sh_d;

    logic                           w_load;
    logic                           w_calib_rise;
    logic                           w_prbs_sel;
    logic [c_WORD_W-1:0]            w_prbs_word;
    logic [c_WORD_W-1:0]            w_lane_word;

`ifdef GEARBOX_PRBS_EN
    logic [6:0] prbs_q, prbs_d;
    logic [6:0] w_prbs_next;

    // Unroll the PRBS7 recurrence over one word; bit 0 is the first generated bit
    always_comb begin
        w_prbs_next = prbs_q;
        w_prbs_word = '0;
        for (int i = 0; i < c_WORD_W; i++) begin
            w_prbs_word[i] = w_prbs_next[6] ^ w_prbs_next[5];
            w_prbs_next    = {w_prbs_next[5:0], w_prbs_next[6] ^ w_prbs_next[5]};
        end
        prbs_d     = w_load ? w_prbs_next : prbs_q;
        w_prbs_sel = prbs_mode;
    end

    // Generator state advances by one word on every load
    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            prbs_q <= 7'h7F;
        end else begin
            prbs_q <= prbs_d;
        end
    end
`else
    assign w_prbs_sel  = 1'b0;
    assign w_prbs_word = '0;
`endif

    // Phase sequencing, slip handling, lane load/shift and underrun counting
    always_comb begin
        ph_d        = ph_q;
        slip_d      = slip_q;
        underrun_d  = underrun_q;
        sh_d        = sh_q;
        w_lane_word = '0;
        calib_d     = calib;

        w_calib_rise = calib & ~calib_q;
        // A pending slip at the last phase postpones the load by one cycle
        w_load       = (ph_q == c_PH_LAST) && !slip_q;

        if (slip_q) begin
            ph_d   = ph_q;
            slip_d = 1'b0;
        end else if (ph_q == c_PH_LAST) begin
            ph_d = '0;
        end else begin
            ph_d = ph_q + c_PH_W'(1);
        end

        // Edges seen while a slip is already pending are dropped
        if (w_calib_rise && !slip_q) begin
            slip_d = 1'b1;
        end

        for (int l = 0; l < NUM_LANES; l++) begin
            if (w_prbs_sel) begin
                w_lane_word = w_prbs_word;
            end else if (data_valid) begin
                w_lane_word = data_in[l*c_WORD_W +: c_WORD_W];
            end else begin
                w_lane_word = IDLE_WORD;
            end
            if (w_load) begin
                sh_d[l*c_WORD_W +: c_WORD_W] = w_lane_word;
            end else begin
                sh_d[l*c_WORD_W +: c_WORD_W] = sh_q[l*c_WORD_W +: c_WORD_W] >> 2;
            end
        end

        if (w_load && !data_valid && !w_prbs_sel && (underrun_q != 8'hFF)) begin
            underrun_d = underrun_q + 8'd1;
        end

        // Registered strobe tracks the phase the next cycle will have
        word_req_d = (ph_d == c_PH_LAST);
    end

    // State registers; reset aborts any word in flight
    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            ph_q       <= '0;
            word_req_q <= 1'b0;
            calib_q    <= 1'b0;
            slip_q     <= 1'b0;
            underrun_q <= 8'd0;
            sh_q       <= '0;
        end else begin
            ph_q       <= ph_d;
            word_req_q <= word_req_d;
            calib_q    <= calib_d;
            slip_q     <= slip_d;
            underrun_q <= underrun_d;
            sh_q       <= sh_d;
        end
    end

    assign word_req     = word_req_q;
    assign underrun_cnt = underrun_q;

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_out
            assign dout_rise[g] = sh_q[g*c_WORD_W];
            assign dout_fall[g] = sh_q[g*c_WORD_W + 1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tmds_gearbox_10to2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmds_gearbox_10to2
//  Summary  : Directed self-checking bench for tmds_gearbox_10to2 (3 lanes,
//             DIV=5). Inputs change and outputs are sampled on falling edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_gearbox_10to2;

    localparam logic [9:0] c_IDLE = 10'b1101010100;

    logic        hclkin     = 1'b0;
    logic        resetn     = 1'b0;
    logic [29:0] data_in    = '0;
    logic        data_valid = 1'b0;
    logic        calib      = 1'b0;
    logic        word_req;
    logic [2:0]  dout_rise;
    logic [2:0]  dout_fall;
    logic [7:0]  underrun_cnt;
`ifdef GEARBOX_PRBS_EN
    logic        prbs_mode  = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    tmds_gearbox_10to2 #(
        .NUM_LANES (3),
        .DIV       (5),
        .IDLE_WORD (10'b1101010100)
    ) dut (
        .hclkin       (hclkin),
        .resetn       (resetn),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .word_req     (word_req),
        .calib        (calib),
        .dout_rise    (dout_rise),
        .dout_fall    (dout_fall),
        .underrun_cnt (underrun_cnt)
`ifdef GEARBOX_PRBS_EN
        ,
        .prbs_mode    (prbs_mode)
`endif
    );

    always #5 hclkin = ~hclkin;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] rep(input logic [9:0] w);
        return {w, w, w};
    endfunction

    // Called on the falling edge where resetn is released; first strobe after 4 edges
    task automatic sync_release(input string tag);
        resetn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge hclkin);
            chk({tag, ":word_req"}, {31'd0, word_req}, {31'd0, (i == 4)});
        end
    endtask

    // Checks one serialised word (5 pairs, or 6 with a slip that ends in a 00 pair).
    // calib_at >= 0 pulses calib at that cycle. nxt_* is applied at cycle 0.
    task automatic expect_word(input string tag, input logic [29:0] cur, input int calib_at,
                               input logic [29:0] nxt_data, input logic nxt_valid);
        int n;
        n = (calib_at < 0) ? 5 : 6;
        for (int c = 0; c < n; c++) begin
            int         ph;
            logic [2:0] er;
            logic [2:0] ef;
            @(negedge hclkin);
            ph = (calib_at >= 0 && c >= calib_at + 2) ? c - 1 : c;
            for (int l = 0; l < 3; l++) begin
                er[l] = (c < 5) ? cur[l*10 + 2*c]     : 1'b0;
                ef[l] = (c < 5) ? cur[l*10 + 2*c + 1] : 1'b0;
            end
            chk({tag, ":rise"},     {29'd0, dout_rise}, {29'd0, er});
            chk({tag, ":fall"},     {29'd0, dout_fall}, {29'd0, ef});
            chk({tag, ":word_req"}, {31'd0, word_req},  {31'd0, (ph == 4)});
            if (c == 0) begin
                data_in    = nxt_data;
                data_valid = nxt_valid;
            end
            if (c == calib_at) calib = 1'b1;
            if (calib_at >= 0 && c == calib_at + 1) calib = 1'b0;
        end
    endtask

    logic [29:0] w_a, w_b, w_c, w_d;
`ifdef GEARBOX_PRBS_EN
    logic [6:0]  s;
    logic [9:0]  pw;
    logic        fb;
`endif

    initial begin
        w_a = {10'h000, 10'h3FF, 10'h2AB};
        w_b = {10'h155, 10'h000, 10'h3FF};
        w_c = {10'h155, 10'h2AB, 10'h3FF};
        w_d = {10'h3FF, 10'h155, 10'h000};

        data_in    = w_a;
        data_valid = 1'b1;
        repeat (2) @(negedge hclkin);
        chk("rst:word_req", {31'd0, word_req},  32'd0);
        chk("rst:rise",     {29'd0, dout_rise}, 32'd0);
        chk("rst:fall",     {29'd0, dout_fall}, 32'd0);
        chk("rst:underrun", {24'd0, underrun_cnt}, 32'd0);

        // First word after release, then independent per-lane patterns
        sync_release("rel1");
        expect_word("word_a", w_a, -1, w_b, 1'b1);
        expect_word("word_b", w_b, -1, w_b, 1'b0);

        // Underrun: IDLE serialised on every lane, counter saturates at 255
        expect_word("idle1", rep(c_IDLE), -1, w_b, 1'b0);
        chk("underrun:1", {24'd0, underrun_cnt}, 32'd1);
        repeat (5*253) @(negedge hclkin);
        chk("underrun:254", {24'd0, underrun_cnt}, 32'd254);
        repeat (5) @(negedge hclkin);
        chk("underrun:255", {24'd0, underrun_cnt}, 32'd255);
        repeat (5*45) @(negedge hclkin);
        chk("underrun:sat", {24'd0, underrun_cnt}, 32'd255);
        expect_word("idle2", rep(c_IDLE), -1, w_c, 1'b1);

        // Slip mid-word, then normal spacing, then slip landing on the load phase
        expect_word("slip_mid",   w_c, 0,  w_c, 1'b1);
        expect_word("post_slip",  w_c, -1, w_c, 1'b1);
        expect_word("slip_last",  w_c, 3,  w_d, 1'b1);
        expect_word("post_slip2", w_d, -1, w_d, 1'b1);
        chk("underrun:hold", {24'd0, underrun_cnt}, 32'd255);

        // Reset asserted at ph=3 of a word in flight
        repeat (4) @(negedge hclkin);
        chk("pre_rst:rise", {29'd0, dout_rise}, 32'd6);
        resetn = 1'b0;
        #1;
        chk("mid_rst:rise",     {29'd0, dout_rise}, 32'd0);
        chk("mid_rst:fall",     {29'd0, dout_fall}, 32'd0);
        chk("mid_rst:word_req", {31'd0, word_req},  32'd0);
        chk("mid_rst:underrun", {24'd0, underrun_cnt}, 32'd0);
        @(negedge hclkin);
        sync_release("rel2");
        expect_word("post_rst", w_d, -1, w_a, 1'b1);
        expect_word("post_rst2", w_a, -1, w_a, 1'b1);

`ifdef GEARBOX_PRBS_EN
        // PRBS7 reference from seed 7'h7F, one word of 10 bits per load
        resetn     = 1'b0;
        prbs_mode  = 1'b1;
        data_valid = 1'b0;
        @(negedge hclkin);
        sync_release("rel_prbs");
        s = 7'h7F;
        for (int wi = 0; wi < 100; wi++) begin
            for (int b = 0; b < 10; b++) begin
                fb    = s[6] ^ s[5];
                pw[b] = fb;
                s     = {s[5:0], fb};
            end
            expect_word("prbs", rep(pw), -1, data_in, 1'b0);
        end
        chk("prbs:underrun", {24'd0, underrun_cnt}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
